// File: rtl/rr_arbiter.sv
// rr_arbiter: N-channel grant controller with fixed-priority or round-robin
// selection, registered one-hot grant, and optional hold-time preemption.
// A release (voluntary or forced) always costs one idle cycle before the next
// grant, and the previous owner competes normally in that cycle.

module rr_arbiter #(
    parameter int N        = 4,
    parameter int MODE     = 1,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           preempt
);

    // One-hot state encoding so that any corrupted pattern is detectably illegal.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_BUSY = 2'b10
    } state_t;

    localparam logic [7:0]     MAX_HOLD_C = 8'(MAX_HOLD);
    localparam logic [IDW-1:0] LAST_IDX_C = IDW'(N - 1);
    localparam logic [IDW-1:0] ONE_IDX_C  = IDW'(1'b1);
    localparam logic [N-1:0]   ONE_HOT_C  = {{(N-1){1'b0}}, 1'b1};

    state_t         state_r;
    state_t         state_s;
    logic [7:0]     hold_cnt_r;
    logic [7:0]     hold_cnt_s;
    logic [IDW-1:0] ptr_r;
    logic [IDW-1:0] ptr_s;
    logic [N-1:0]   gnt_r;
    logic [N-1:0]   gnt_s;
    logic           gnt_valid_r;
    logic           gnt_valid_s;
    logic [IDW-1:0] gnt_id_r;
    logic [IDW-1:0] gnt_id_s;
    logic           preempt_r;
    logic           preempt_s;
    logic [IDW-1:0] search_start_s;
    logic [IDW-1:0] winner_s;
    logic           owner_req_s;
    logic           others_req_s;

    // First requesting channel found when scanning upward from start with wrap.
    function automatic logic [IDW-1:0] pick_winner(
        input logic [N-1:0]   r,
        input logic [IDW-1:0] start
    );
        logic [IDW-1:0] win;
        logic [IDW-1:0] cand;
        logic           found;
        win   = '0;
        cand  = start;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && r[cand]) begin
                win   = cand;
                found = 1'b1;
            end else begin
                win   = win;
                found = found;
            end
            if (cand == LAST_IDX_C) begin
                cand = '0;
            end else begin
                cand = cand + ONE_IDX_C;
            end
        end
        return win;
    endfunction

    // Fixed priority always scans from channel 0; round-robin scans from ptr.
    assign search_start_s = (MODE == 1) ? ptr_r : '0;
    assign winner_s       = pick_winner(req, search_start_s);
    assign owner_req_s    = req[gnt_id_r];
    assign others_req_s   = |(req & ~gnt_r);

    // Next-state, counter, pointer and output computation.
    always_comb begin
        state_s     = state_r;
        hold_cnt_s  = hold_cnt_r;
        ptr_s       = ptr_r;
        gnt_s       = gnt_r;
        gnt_valid_s = gnt_valid_r;
        gnt_id_s    = gnt_id_r;
        preempt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_s     = ST_BUSY;
                    hold_cnt_s  = 8'd1;
                    gnt_s       = ONE_HOT_C << winner_s;
                    gnt_valid_s = 1'b1;
                    gnt_id_s    = winner_s;
                    if (MODE == 1) begin
                        if (winner_s == LAST_IDX_C) begin
                            ptr_s = '0;
                        end else begin
                            ptr_s = winner_s + ONE_IDX_C;
                        end
                    end else begin
                        ptr_s = '0;
                    end
                end else begin
                    state_s     = ST_IDLE;
                    hold_cnt_s  = 8'd0;
                    gnt_s       = '0;
                    gnt_valid_s = 1'b0;
                    gnt_id_s    = '0;
                end
            end
            ST_BUSY: begin
                if (!owner_req_s) begin
                    state_s     = ST_IDLE;
                    hold_cnt_s  = 8'd0;
                    gnt_s       = '0;
                    gnt_valid_s = 1'b0;
                    gnt_id_s    = '0;
                end else if ((MAX_HOLD_C != 8'd0) && (hold_cnt_r == MAX_HOLD_C) && others_req_s) begin
                    state_s     = ST_IDLE;
                    hold_cnt_s  = 8'd0;
                    gnt_s       = '0;
                    gnt_valid_s = 1'b0;
                    gnt_id_s    = '0;
                    preempt_s   = 1'b1;
                end else begin
                    state_s = ST_BUSY;
                    if (hold_cnt_r < MAX_HOLD_C) begin
                        hold_cnt_s = hold_cnt_r + 8'd1;
                    end else begin
                        hold_cnt_s = hold_cnt_r;
                    end
                end
            end
            default: begin
                state_s     = ST_IDLE;
                hold_cnt_s  = 8'd0;
                gnt_s       = '0;
                gnt_valid_s = 1'b0;
                gnt_id_s    = '0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            hold_cnt_r  <= 8'd0;
            ptr_r       <= '0;
            gnt_r       <= '0;
            gnt_valid_r <= 1'b0;
            gnt_id_r    <= '0;
            preempt_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            hold_cnt_r  <= hold_cnt_s;
            ptr_r       <= ptr_s;
            gnt_r       <= gnt_s;
            gnt_valid_r <= gnt_valid_s;
            gnt_id_r    <= gnt_id_s;
            preempt_r   <= preempt_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_valid = gnt_valid_r;
    assign gnt_id    = gnt_id_r;
    assign preempt   = preempt_r;

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesting channels, legal range 2..16.
REQ-002 Parameter MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-003 Parameter MAX_HOLD, default 16: maximum consecutive grant cycles before preemption, legal range 0..255; 0 disables preemption.
REQ-004 Parameter IDW, default $clog2(N): width of gnt_id.
REQ-005 clk  input  1  the single clock; all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset; low forces reset state immediately, with release sampled on clk.
REQ-007 req  input  N  request vector; req[i] high means channel i wants or keeps ownership.
REQ-008 gnt  output  N  registered one-hot grant; all zero when no owner.
REQ-009 gnt_valid  output  1  registered; equals OR of gnt.
REQ-010 gnt_id  output  IDW  registered index of the current owner; 0 when gnt_valid is low.
REQ-011 preempt  output  1  registered one-cycle pulse marking a timeout-forced release.

Function
REQ-012 The controller SHALL implement two states: IDLE (no owner) and BUSY (one owner).
REQ-013 In IDLE with req==0, the block SHALL stay in IDLE with all outputs low.
REQ-014 In IDLE with req!=0 at edge k, the block SHALL select one winner, and from edge k drive gnt=onehot(winner), gnt_valid=1, gnt_id=winner, enter BUSY, and load hold_cnt=1.
REQ-015 The grant latency from a request seen in IDLE SHALL be 1 cycle, i.e. the grant is visible after the next rising edge.
REQ-016 MODE=0 SHALL pick the lowest set index of req.
REQ-017 MODE=1 SHALL pick the first set index at or after ptr, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1, modulo N.
REQ-018 In MODE=1, ptr SHALL update to (winner+1) mod N at each grant, and wrap from N-1 to 0.
REQ-019 In MODE=0, ptr SHALL be unused and held at 0.
REQ-020 In BUSY, a low req[owner] at an edge SHALL clear gnt, gnt_valid and gnt_id at that edge and return the block to IDLE.
REQ-021 In BUSY with req[owner] high, MAX_HOLD!=0, hold_cnt==MAX_HOLD and any other req bit high at an edge, the block SHALL clear the grant, pulse preempt for one cycle, and return to IDLE.
REQ-022 In BUSY with req[owner] high and no release condition, the grant SHALL hold and hold_cnt SHALL increment, saturating at MAX_HOLD.
REQ-023 When hold_cnt==MAX_HOLD and no other request is pending, the owner SHALL keep the grant indefinitely with no preemption.
REQ-024 Every release, whether voluntary or preempted, SHALL be followed by at least one IDLE cycle with gnt==0 before any new grant.
REQ-025 A new grant SHALL be re-arbitrated in that IDLE cycle, and the previous owner SHALL be eligible to win again.
REQ-026 Changes in req bits of non-owners while BUSY SHALL have no effect on gnt.
REQ-027 gnt SHALL never have more than one bit set, and no channel SHALL receive gnt while its req was low at the granting edge.
REQ-028 In MODE=1 with all channels requesting continuously and MAX_HOLD>0, every channel SHALL be granted within N grant periods, with no starvation.
REQ-029 Any illegal state encoding SHALL recover to IDLE on the next edge with all outputs low.

Reset
REQ-030 While rst is low, the block SHALL hold state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, preempt=0, hold_cnt=0 and ptr=0, asynchronously and independent of clk.
REQ-031 Assertion of rst mid-grant SHALL drop gnt immediately, without waiting for a clock edge.
REQ-032 After rst rises, the first arbitration SHALL occur at the first rising edge where rst is high and req!=0.

Verification
REQ-033 Reset then single request: N=4, MODE=1, req=0100 held -> gnt=0100 and gnt_id=2 one edge later; req=0000 -> gnt=0000 next edge.
REQ-034 Round-robin rotation: MODE=1, MAX_HOLD=0, req=1111 with each owner dropping its req one cycle after grant -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-035 Fixed priority: MODE=0, req=1010, then owner 1 releases while req[3] stays high -> gnt=0010 first, idle cycle, then gnt=1000.
REQ-036 Preemption: MAX_HOLD=4, req=0011 held -> gnt=0001 for exactly 4 cycles, preempt=1 for one cycle with gnt=0, then gnt=0010.
REQ-037 No preemption without contention: MAX_HOLD=4, only req[0] held for 20 cycles -> gnt=0001 throughout and preempt never asserts.
REQ-038 Asynchronous reset mid-grant: gnt=0100 and rst driven low between edges -> all outputs 0 before the next edge; after release with req=1111, the first grant goes to channel 0 (ptr=0).
